// File: rtl/time_set_ctrl.sv
// time_set_ctrl: seconds/minutes/hours counters with a RUN/SET_HR/SET_MIN time-set FSM and blink strobes
// Optional feature macro: CLOCK_12H_EN (12-hour mode, Hours 1..12, adds pm port).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   btn_mode          1-cycle pulse, advances RUN->SET_HR->SET_MIN->RUN
//   btn_inc           1-cycle pulse, increments the field being set
//   Minutes, Hours    registered time fields feeding the digit splitter
//   Seconds           registered seconds 0..59
//   sec_tick          1-cycle pulse when Seconds advances
//   blink_hours       1 = blank hour digits this cycle
//   blink_minutes     1 = blank minute digits this cycle
//   pm                (CLOCK_12H_EN only) 1 = PM
module time_set_ctrl #(
  parameter int CLK_HZ = 100_000_000,
  parameter int DWL = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           btn_mode,
  input  logic           btn_inc,
  output logic [DWL-3:0] Minutes,
  output logic [DWL-4:0] Hours,
  output logic [5:0]     Seconds,
  output logic           sec_tick,
  output logic           blink_hours,
  output logic           blink_minutes
`ifdef CLOCK_12H_EN
  ,
  output logic           pm
`endif
);
  localparam int MW = DWL - 2;
  localparam int HW = DWL - 3;
  localparam int CW = $clog2(CLK_HZ);
  localparam int BW = $clog2(CLK_HZ / 2);
`ifdef CLOCK_12H_EN
  localparam logic [HW-1:0] HR_RST = HW'(12);
`else
  localparam logic [HW-1:0] HR_RST = '0;
`endif
  typedef enum logic [1:0] {RUN, SET_HR, SET_MIN} state_t;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bcnt;
  logic          phase;
  logic          tick, sec_wrap, min_wrap, bterm;
  logic [MW-1:0] min_nxt;
  logic [HW-1:0] hr_nxt;
  assign tick     = cnt == CW'(CLK_HZ - 1);
  assign bterm    = bcnt == BW'(CLK_HZ / 2 - 1);
  assign sec_wrap = Seconds == 6'd59;
  assign min_wrap = Minutes == MW'(59);
  assign min_nxt  = min_wrap ? '0 : Minutes + MW'(1);
`ifdef CLOCK_12H_EN
  assign hr_nxt   = (Hours == HW'(12)) ? HW'(1) : Hours + HW'(1);
`else
  assign hr_nxt   = (Hours == HW'(23)) ? '0 : Hours + HW'(1);
`endif
  assign blink_hours   = (state == SET_HR) & phase;
  assign blink_minutes = (state == SET_MIN) & phase;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      Seconds  <= '0;
      Minutes  <= '0;
      Hours    <= HR_RST;
      cnt      <= '0;
      bcnt     <= '0;
      phase    <= 1'b0;
      sec_tick <= 1'b0;
`ifdef CLOCK_12H_EN
      pm       <= 1'b0;
`endif
    end else begin
      sec_tick <= 1'b0;
      case (state)
        RUN: begin
          cnt <= tick ? '0 : cnt + CW'(1);
          // A tick coinciding with btn_mode still lands; SET_HR zeroes Seconds afterwards.
          if (tick) begin
            sec_tick <= 1'b1;
            Seconds  <= sec_wrap ? '0 : Seconds + 6'd1;
            if (sec_wrap) Minutes <= min_nxt;
            if (sec_wrap && min_wrap) begin
              Hours <= hr_nxt;
`ifdef CLOCK_12H_EN
              if (Hours == HW'(11)) pm <= ~pm;
`endif
            end
          end
          if (btn_mode) begin
            state <= SET_HR;
            phase <= 1'b0;
            bcnt  <= '0;
          end
        end
        SET_HR, SET_MIN: begin
          cnt     <= '0;
          Seconds <= '0;
          if (btn_mode) begin
            state <= (state == SET_HR) ? SET_MIN : RUN;
            phase <= 1'b0;
            bcnt  <= '0;
          end else if (btn_inc) begin
            // Restart the blink so the edited field shows right away.
            phase <= 1'b0;
            bcnt  <= '0;
            if (state == SET_HR) begin
              Hours <= hr_nxt;
`ifdef CLOCK_12H_EN
              if (Hours == HW'(11)) pm <= ~pm;
`endif
            end else begin
              Minutes <= min_nxt;
            end
          end else begin
            bcnt <= bterm ? '0 : bcnt + BW'(1);
            if (bterm) phase <= ~phase;
          end
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: scoreboard bench for time_set_ctrl at CLK_HZ=10
module tb_time_set_ctrl;
  localparam int CLK_HZ = 10;
  localparam int DWL = 8;
`ifdef CLOCK_12H_EN
  localparam int H0 = 12;
`else
  localparam int H0 = 0;
`endif
  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           btn_mode = 1'b0;
  logic           btn_inc = 1'b0;
  logic [DWL-3:0] Minutes;
  logic [DWL-4:0] Hours;
  logic [5:0]     Seconds;
  logic           sec_tick, blink_hours, blink_minutes;
`ifdef CLOCK_12H_EN
  logic           pm;
`endif
  int n_cmp = 0;
  int n_err = 0;
  int lat = -1;
  typedef struct {
    string tag;
    int    sig;
    int    val;
  } exp_t;
  exp_t sb[$];
  time_set_ctrl #(.CLK_HZ(CLK_HZ), .DWL(DWL)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_mode(btn_mode),
    .btn_inc(btn_inc),
    .Minutes(Minutes),
    .Hours(Hours),
    .Seconds(Seconds),
    .sec_tick(sec_tick),
    .blink_hours(blink_hours),
    .blink_minutes(blink_minutes)
`ifdef CLOCK_12H_EN
    ,
    .pm(pm)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask
  function automatic int probe(input int sig);
    case (sig)
      0: return int'(Hours);
      1: return int'(Minutes);
      2: return int'(Seconds);
      3: return int'(sec_tick);
      4: return int'(blink_hours);
      5: return int'(blink_minutes);
`ifdef CLOCK_12H_EN
      6: return int'(pm);
`endif
      7: return lat;
      default: return -1;
    endcase
  endfunction
  task automatic want(input string tag, input int sig, input int val);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = val;
    sb.push_back(e);
  endtask
  task automatic want_time(input string tag, input int h, input int m, input int s, input int t);
    want({tag, ".h"}, 0, h);
    want({tag, ".m"}, 1, m);
    want({tag, ".s"}, 2, s);
    want({tag, ".tick"}, 3, t);
  endtask
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, probe(e.sig), e.val);
    end
  endtask
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic press(input logic m, input logic i);
    @(negedge clk);
    btn_mode = m;
    btn_inc = i;
    @(negedge clk);
    btn_mode = 1'b0;
    btn_inc = 1'b0;
  endtask
  task automatic do_reset();
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    want_time("reset", H0, 0, 0, 0);
    want("reset.bh", 4, 0);
    want("reset.bm", 5, 0);
`ifdef CLOCK_12H_EN
    want("reset.pm", 6, 0);
`endif
    drain();
    rst_n = 1'b1;
  endtask
  task automatic measure(input int bound);
    lat = -1;
    for (int c = 1; c <= bound && lat < 0; c++) begin
      @(negedge clk);
      if (sec_tick) lat = c;
    end
  endtask
  initial begin
    do_reset();
    cycles(9);
    want_time("pre_tick", H0, 0, 0, 0);
    drain();
    cycles(1);
    want_time("first_tick", H0, 0, 1, 1);
    drain();
    cycles(1);
    want("tick_end", 3, 0);
    drain();
`ifndef CLOCK_12H_EN
    do_reset();
    press(1, 0);
    repeat (23) press(0, 1);
    press(1, 0);
    repeat (59) press(0, 1);
    press(1, 0);
    want_time("preload", 23, 59, 0, 0);
    drain();
    cycles(590);
    want_time("at_59", 23, 59, 59, 1);
    drain();
    cycles(9);
    want_time("hold_59", 23, 59, 59, 0);
    drain();
    cycles(1);
    want_time("rollover", 0, 0, 0, 1);
    drain();
    cycles(1);
    want("rollover_end", 3, 0);
    drain();
`endif
    do_reset();
    press(1, 0);
    repeat (5) press(0, 1);
    press(1, 0);
    repeat (61) press(0, 1);
    press(1, 0);
    want_time("set_5_1", 5, 1, 0, 0);
    want("run.bh", 4, 0);
    want("run.bm", 5, 0);
    drain();
    measure(20);
    want("resume_lat", 7, 10);
    want("resume_s", 2, 1);
    drain();
    do_reset();
    press(1, 0);
    repeat (3) press(0, 1);
    cycles(4);
    want("bh_pre", 4, 0);
    drain();
    cycles(1);
    want("bh_on", 4, 1);
    want("bm_in_hr", 5, 0);
    drain();
    press(1, 1);
    want("collide.h", 0, 3);
    want("collide.m", 1, 0);
    want("collide.bh", 4, 0);
    drain();
    press(0, 1);
    want("setmin.m", 1, 1);
    want("setmin.h", 0, 3);
    drain();
    cycles(4);
    want("bm_pre", 5, 0);
    drain();
    cycles(1);
    want("bm_on", 5, 1);
    want("bh_in_min", 4, 0);
    drain();
    cycles(4);
    want("bm_hold", 5, 1);
    drain();
    cycles(1);
    want("bm_off", 5, 0);
    drain();
    cycles(5);
    want("bm_on2", 5, 1);
    drain();
    press(0, 1);
    want("inc_clr.bm", 5, 0);
    want("inc_clr.m", 1, 2);
    drain();
    do_reset();
    cycles(8);
    press(1, 0);
    want_time("tick_mode", H0, 0, 1, 1);
    drain();
    cycles(1);
    want_time("sec_clr", H0, 0, 0, 0);
    drain();
`ifdef CLOCK_12H_EN
    do_reset();
    press(1, 0);
    repeat (11) press(0, 1);
    want("h11", 0, 11);
    want("h11.pm", 6, 0);
    drain();
    press(0, 1);
    want("h12", 0, 12);
    want("h12.pm", 6, 1);
    drain();
    press(0, 1);
    want("h1", 0, 1);
    want("h1.pm", 6, 1);
    drain();
    do_reset();
    cycles(10);
    want_time("run_after_rst", 12, 0, 1, 1);
    drain();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #500_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "bench timeout");
  end
endmodule
